sequence_checker: RTL and testbench

Downstream consumer for the repeating 3-bit symbol stream produced by the sequence generator. It acquires alignment to a known periodic pattern, then checks every subsequent symbol against it. It reports lock status, single-cycle mismatch and period-complete strobes, and a saturating error count. It lets the generator be verified in-system or on the bench without a reference model.

---
 rtl/seq_pkg.sv | 23 ++
 rtl/sat_counter.sv | 32 +++
 rtl/sequence_checker.sv | 137 +++++++++++++
 tb/tb_sequence_checker.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the sequence generator/checker pair: symbol width,
// default pattern, checker state encoding and a pattern element extractor.
package seq_pkg;

  localparam int SYM_W   = 3;
  localparam int MAX_LEN = 8;
  localparam int PAT_W   = SYM_W * MAX_LEN;

  // Symbols 0,1,...,7 packed with element 0 in the least significant bits.
  localparam logic [PAT_W-1:0] DEFAULT_PATTERN = 24'hFAC688;

  typedef enum logic [1:0] {
    HUNT,
    ACQUIRE,
    LOCKED
  } state_t;

  function automatic logic [SYM_W-1:0] sym_at(input logic [PAT_W-1:0] pattern,
                                              input int i);
    return pattern[SYM_W*i +: SYM_W];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// Count is registered: an inc sampled at an edge is visible right after that edge.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sequence_checker.sv
// Aligns to a periodic 3-bit symbol pattern, then checks each qualified symbol,
// reporting lock, mismatch/period strobes and a saturating error count (1-cycle latency).
module sequence_checker
  import seq_pkg::*;
#(
  parameter int               SEQ_LEN    = 8,
  parameter logic [PAT_W-1:0] PATTERN    = DEFAULT_PATTERN,
  parameter int               MISS_LIMIT = 2,
  parameter int               ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SYM_W-1:0] din,
  input  logic             din_en,
  output logic             locked,
  output logic             mismatch,
  output logic             seq_done,
  output logic [ERR_W-1:0] err_count
);

  localparam int IDX_W  = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(SEQ_LEN - 1);
  localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MISS_LIMIT);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              locked_q;
  logic              mismatch_q, mismatch_d;
  logic              seq_done_q, seq_done_d;

  logic              hit;
  logic              hit_first;
  logic              is_last;
  logic [IDX_W-1:0]  idx_inc;
  logic [MISS_W-1:0] miss_inc;

  assign hit       = (din == sym_at(PATTERN, int'(idx_q)));
  assign hit_first = (din == sym_at(PATTERN, 0));
  assign is_last   = (idx_q == LAST_IDX);
  assign idx_inc   = is_last ? '0 : idx_q + IDX_W'(1);
  assign miss_inc  = miss_q + MISS_W'(1);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    miss_d     = miss_q;
    mismatch_d = 1'b0;
    seq_done_d = 1'b0;

    if (din_en) begin
      case (state_q)
        HUNT: begin
          if (hit_first) begin
            state_d = ACQUIRE;
            idx_d   = IDX_W'(1);
          end
        end

        ACQUIRE: begin
          if (hit) begin
            if (is_last) begin
              state_d = LOCKED;
              idx_d   = '0;
              miss_d  = '0;
            end else begin
              idx_d = idx_inc;
            end
          end else if (hit_first) begin
            // A broken run may itself be the start of a fresh period.
            idx_d = IDX_W'(1);
          end else begin
            state_d = HUNT;
            idx_d   = '0;
          end
        end

        LOCKED: begin
          // Flywheel: position advances regardless of symbol correctness.
          idx_d = idx_inc;
          if (!hit) begin
            mismatch_d = 1'b1;
            miss_d     = miss_inc;
          end
          if (!hit && (miss_inc == MISS_MAX)) begin
            state_d = HUNT;
            idx_d   = '0;
            miss_d  = '0;
          end else if (is_last) begin
            seq_done_d = 1'b1;
            miss_d     = '0;
          end
        end

        default: begin
          state_d = HUNT;
          idx_d   = '0;
          miss_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= HUNT;
      idx_q      <= '0;
      miss_q     <= '0;
      locked_q   <= 1'b0;
      mismatch_q <= 1'b0;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      miss_q     <= miss_d;
      locked_q   <= (state_d == LOCKED);
      mismatch_q <= mismatch_d;
      seq_done_q <= seq_done_d;
    end
  end

  sat_counter #(
    .WIDTH(ERR_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (mismatch_d),
    .count(err_count)
  );

  assign locked   = locked_q;
  assign mismatch = mismatch_q;
  assign seq_done = seq_done_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Directed checks of sequence_checker with the default 0..7 pattern,
// MISS_LIMIT=2 and an 8-bit error counter.
module tb_sequence_checker;

  logic       clk;
  logic       rst;
  logic [2:0] din;
  logic       din_en;
  logic       locked;
  logic       mismatch;
  logic       seq_done;
  logic [7:0] err_count;

  int total = 0;
  int bad   = 0;

  sequence_checker #(
    .SEQ_LEN   (8),
    .PATTERN   (24'hFAC688),
    .MISS_LIMIT(2),
    .ERR_W     (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_en   (din_en),
    .locked   (locked),
    .mismatch (mismatch),
    .seq_done (seq_done),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input logic [2:0] d, input logic en);
    din    = d;
    din_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic l, input logic m,
                           input logic s, input logic [7:0] e);
    chk({tag, ".locked"},    32'(locked),    32'(l));
    chk({tag, ".mismatch"},  32'(mismatch),  32'(m));
    chk({tag, ".seq_done"},  32'(seq_done),  32'(s));
    chk({tag, ".err_count"}, 32'(err_count), 32'(e));
  endtask

  initial begin
    rst    = 1'b0;
    din    = 3'd0;
    din_en = 1'b1;

    // Reset state
    send(3'd0, 1'b1);
    send(3'd0, 1'b1);
    check_out("reset", 1'b0, 1'b0, 1'b0, 8'd0);
    rst = 1'b1;

    // Clean 0..7 stream from reset
    for (int i = 0; i < 7; i++) send(3'(i), 1'b1);
    check_out("pre_lock1", 1'b0, 1'b0, 1'b0, 8'd0);
    send(3'd7, 1'b1);
    check_out("lock1", 1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 7; i++) send(3'(i), 1'b1);
    check_out("pre_done1", 1'b1, 1'b0, 1'b0, 8'd0);
    send(3'd7, 1'b1);
    check_out("done1", 1'b1, 1'b0, 1'b1, 8'd0);
    send(3'd0, 1'b1);
    check_out("done1_clr", 1'b1, 1'b0, 1'b0, 8'd0);

    // Reset then leading garbage ignored by HUNT
    rst = 1'b0;
    send(3'd3, 1'b1);
    rst = 1'b1;
    check_out("reset2", 1'b0, 1'b0, 1'b0, 8'd0);
    send(3'd5, 1'b1);
    send(3'd6, 1'b1);
    check_out("hunt_ignore", 1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 7; i++) send(3'(i), 1'b1);
    check_out("pre_lock2", 1'b0, 1'b0, 1'b0, 8'd0);
    send(3'd7, 1'b1);
    check_out("lock2", 1'b1, 1'b0, 1'b0, 8'd0);

    // Single corrupted symbol: 3 replaced by 6
    send(3'd0, 1'b1);
    send(3'd1, 1'b1);
    send(3'd2, 1'b1);
    send(3'd6, 1'b1);
    check_out("bad1", 1'b1, 1'b1, 1'b0, 8'd1);
    send(3'd4, 1'b1);
    check_out("bad1_clr", 1'b1, 1'b0, 1'b0, 8'd1);
    send(3'd5, 1'b1);
    send(3'd6, 1'b1);
    send(3'd7, 1'b1);
    check_out("bad1_done", 1'b1, 1'b0, 1'b1, 8'd1);

    // Two corrupted symbols in one period lose lock
    send(3'd0, 1'b1);
    send(3'd1, 1'b1);
    send(3'd7, 1'b1);
    check_out("bad2a", 1'b1, 1'b1, 1'b0, 8'd2);
    send(3'd3, 1'b1);
    send(3'd4, 1'b1);
    send(3'd0, 1'b1);
    check_out("bad2b", 1'b0, 1'b1, 1'b0, 8'd3);
    send(3'd6, 1'b1);
    send(3'd7, 1'b1);
    check_out("no_done", 1'b0, 1'b0, 1'b0, 8'd3);
    for (int i = 0; i < 7; i++) send(3'(i), 1'b1);
    check_out("pre_relock", 1'b0, 1'b0, 1'b0, 8'd3);
    send(3'd7, 1'b1);
    check_out("relock", 1'b1, 1'b0, 1'b0, 8'd3);

    // Qualifier low with garbage: everything frozen
    send(3'd0, 1'b1);
    send(3'd1, 1'b1);
    send(3'd2, 1'b1);
    for (int k = 0; k < 5; k++) begin
      send(3'd5, 1'b0);
      check_out("en_low", 1'b1, 1'b0, 1'b0, 8'd3);
    end
    send(3'd3, 1'b1);
    check_out("resume", 1'b1, 1'b0, 1'b0, 8'd3);
    send(3'd4, 1'b1);
    send(3'd5, 1'b1);
    send(3'd6, 1'b1);
    send(3'd7, 1'b1);
    check_out("resume_done", 1'b1, 1'b0, 1'b1, 8'd3);

    // Mid-period reset discards alignment and errors
    send(3'd0, 1'b1);
    send(3'd1, 1'b1);
    send(3'd5, 1'b1);
    check_out("bad3", 1'b1, 1'b1, 1'b0, 8'd4);
    rst = 1'b0;
    send(3'd2, 1'b1);
    rst = 1'b1;
    check_out("reset3", 1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 3; i < 8; i++) send(3'(i), 1'b1);
    check_out("post_rst_hunt", 1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 7; i++) send(3'(i), 1'b1);
    check_out("pre_lock3", 1'b0, 1'b0, 1'b0, 8'd0);
    send(3'd7, 1'b1);
    check_out("lock3", 1'b1, 1'b0, 1'b0, 8'd0);

    // Saturation: 150 rounds of two errors then relock
    for (int r = 0; r < 150; r++) begin
      send(3'd7, 1'b1);
      send(3'd7, 1'b1);
      if (r == 126) chk("sat_254", 32'(err_count), 32'd254);
      if (r == 127) chk("sat_255", 32'(err_count), 32'd255);
      if (r == 149) check_out("sat_end", 1'b0, 1'b1, 1'b0, 8'd255);
      for (int i = 0; i < 8; i++) send(3'(i), 1'b1);
    end
    check_out("sat_relock", 1'b1, 1'b0, 1'b0, 8'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
